// File: rtl/axis_insert_header_pkt.sv
// rtl/axis_insert_header_pkt.sv - streaming header inserter with dense byte re-packing and one-entry header buffer
module axis_insert_header_pkt #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert,
    output logic                    err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

    localparam logic [BYTE_CNT_WD-1:0]  W_CNT    = BYTE_CNT_WD'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

    // MSB-aligned keep with m leading ones
    function automatic logic [DATA_BYTE_WD-1:0] top_ones(input logic [BYTE_CNT_WD:0] m);
        return ~(KEEP_ALL >> m);
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction

    function automatic logic [BYTE_CNT_WD-1:0] count_ones(input logic [DATA_BYTE_WD-1:0] keep);
        logic [BYTE_CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + BYTE_CNT_WD'(keep[i]);
        return c;
    endfunction

    state_t                  r_state;
    logic                    r_hdr_v;
    logic [DATA_WD-1:0]      r_hdr_data;
    logic [BYTE_CNT_WD-1:0]  r_hdr_cnt;
    logic [DATA_WD-1:0]      r_hold;       // pending bytes, MSB-aligned, unused bytes zero
    logic [BYTE_CNT_WD-1:0]  r_h;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;
    logic                    r_err;

    state_t                  w_state_nx;
    logic                    w_hdr_v_nx;
    logic [DATA_WD-1:0]      w_hdr_data_nx;
    logic [BYTE_CNT_WD-1:0]  w_hdr_cnt_nx;
    logic [DATA_WD-1:0]      w_hold_nx;
    logic [BYTE_CNT_WD-1:0]  w_h_nx;
    logic                    w_valid_nx;
    logic [DATA_WD-1:0]      w_data_nx;
    logic [DATA_BYTE_WD-1:0] w_keep_nx;
    logic                    w_last_nx;
    logic                    w_err_nx;

    logic                    w_adv;
    logic                    w_hdr_acc;
    logic                    w_beat_acc;
    logic                    w_hdr_bad;
    logic [BYTE_CNT_WD-1:0]  w_cnt_clamp;
    logic [BYTE_CNT_WD-1:0]  w_k;
    logic [BYTE_CNT_WD:0]    w_sum;
    logic [DATA_WD-1:0]      w_din;
    logic [BYTE_CNT_WD-1:0]  w_wmh;
    logic [BYTE_CNT_WD-1:0]  w_hdr_wmn;
    logic [DATA_WD-1:0]      w_hdr_hold;
    logic                    w_load;
    logic                    w_emit;
    logic [DATA_WD-1:0]      w_e_data;
    logic [DATA_BYTE_WD-1:0] w_e_keep;
    logic                    w_e_last;

    assign w_adv        = !r_valid_out || ready_out;
    assign ready_in     = rst_n && (r_state == S_DATA) && w_adv;
    assign ready_insert = rst_n && !r_hdr_v;
    assign w_hdr_acc    = valid_insert && ready_insert;
    assign w_beat_acc   = valid_in && ready_in;
    assign w_hdr_bad    = (keep_insert != ~(KEEP_ALL << byte_insert_cnt)) || (byte_insert_cnt > W_CNT);
    assign w_cnt_clamp  = (byte_insert_cnt > W_CNT) ? W_CNT : byte_insert_cnt;
    assign w_k          = count_ones(keep_in);
    assign w_sum        = {1'b0, r_h} + {1'b0, w_k};
    // bytes past keep on the last beat are zeroed so they never leak into output lanes
    assign w_din        = last_in ? (data_in & byte_mask(keep_in)) : data_in;
    assign w_wmh        = W_CNT - r_h;
    assign w_hdr_wmn    = W_CNT - r_hdr_cnt;
    assign w_hdr_hold   = r_hdr_data << {w_hdr_wmn, 3'b000};

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;
    assign last_out  = r_last_out;
    assign err       = r_err;

    // next-state, header buffering, byte packing and output-stage update
    always_comb begin
        w_state_nx    = r_state;
        w_hdr_v_nx    = r_hdr_v;
        w_hdr_data_nx = r_hdr_data;
        w_hdr_cnt_nx  = r_hdr_cnt;
        w_hold_nx     = r_hold;
        w_h_nx        = r_h;
        w_valid_nx    = r_valid_out;
        w_data_nx     = r_data_out;
        w_keep_nx     = r_keep_out;
        w_last_nx     = r_last_out;
        w_err_nx      = r_err;
        w_load        = 1'b0;
        w_emit        = 1'b0;
        w_e_data      = '0;
        w_e_keep      = '0;
        w_e_last      = 1'b0;

        if (w_hdr_acc) begin
            w_hdr_v_nx    = 1'b1;
            w_hdr_data_nx = data_insert;
            w_hdr_cnt_nx  = w_cnt_clamp;
            if (w_hdr_bad) w_err_nx = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (r_hdr_v) w_load = 1'b1;
            end
            S_DATA: begin
                if (w_beat_acc) begin
                    w_emit   = 1'b1;
                    w_e_data = r_hold | (w_din >> {r_h, 3'b000});
                    w_e_keep = KEEP_ALL;
                    if (!last_in) begin
                        if (keep_in != KEEP_ALL) w_err_nx = 1'b1;
                        w_hold_nx = w_din << {w_wmh, 3'b000};
                    end else begin
                        if (keep_in == '0) w_err_nx = 1'b1;
                        if (w_sum <= {1'b0, W_CNT}) begin
                            w_e_keep   = top_ones(w_sum);
                            w_e_last   = 1'b1;
                            w_state_nx = S_IDLE;
                            if (r_hdr_v) w_load = 1'b1;
                        end else begin
                            // overflow bytes spill into one extra TAIL beat
                            w_hold_nx  = w_din << {w_wmh, 3'b000};
                            w_h_nx     = BYTE_CNT_WD'(w_sum - {1'b0, W_CNT});
                            w_state_nx = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (w_adv) begin
                    w_emit     = 1'b1;
                    w_e_data   = r_hold;
                    w_e_keep   = top_ones({1'b0, r_h});
                    w_e_last   = 1'b1;
                    w_state_nx = S_IDLE;
                    if (r_hdr_v) w_load = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // buffered header becomes the new hold content; reaching here from a
        // last beat keeps the stream in DATA with no idle cycle
        if (w_load) begin
            w_hold_nx  = w_hdr_hold;
            w_h_nx     = r_hdr_cnt;
            w_hdr_v_nx = 1'b0;
            w_state_nx = S_DATA;
        end

        if (w_adv) begin
            w_valid_nx = w_emit;
            w_data_nx  = w_e_data;
            w_keep_nx  = w_e_keep;
            w_last_nx  = w_e_last;
        end
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hdr_v     <= 1'b0;
            r_hdr_data  <= '0;
            r_hdr_cnt   <= '0;
            r_hold      <= '0;
            r_h         <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hdr_v     <= w_hdr_v_nx;
            r_hdr_data  <= w_hdr_data_nx;
            r_hdr_cnt   <= w_hdr_cnt_nx;
            r_hold      <= w_hold_nx;
            r_h         <= w_h_nx;
            r_valid_out <= w_valid_nx;
            r_data_out  <= w_data_nx;
            r_keep_out  <= w_keep_nx;
            r_last_out  <= w_last_nx;
            r_err       <= w_err_nx;
        end
    end

endmodule

// File: tb/tb_axis_insert_header_pkt.sv
// tb/tb_axis_insert_header_pkt.sv - self-checking bench for axis_insert_header_pkt
module tb_axis_insert_header_pkt;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [W-1:0]  keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;
    logic          last_out;
    logic          ready_out;
    logic          valid_insert = 1'b0;
    logic [DW-1:0] data_insert = '0;
    logic [W-1:0]  keep_insert = '0;
    logic [CW-1:0] byte_insert_cnt = '0;
    logic          ready_insert;
    logic          err;

    axis_insert_header_pkt #(.DATA_WD(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int stall_viol = 0;

    logic [DW-1:0] pl_d[$];
    logic [W-1:0]  pl_k[$];
    logic          pl_l[$];
    int            in_cyc[$];
    logic [DW-1:0] exp_d[$];
    logic [W-1:0]  exp_k[$];
    logic          exp_l[$];
    logic [DW-1:0] obs_d[$];
    logic [W-1:0]  obs_k[$];
    logic          obs_l[$];
    int            obs_c[$];

    logic             prev_stall = 1'b0;
    logic [DW+W+1:0]  prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // capture completed output beats and watch for changes while stalled
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            obs_d.push_back(data_out);
            obs_k.push_back(keep_out);
            obs_l.push_back(last_out);
            obs_c.push_back(cyc);
        end
        if (rst_n && prev_stall && ({valid_out, data_out, keep_out, last_out} !== prev_out))
            stall_viol <= stall_viol + 1;
        prev_stall <= rst_n && valid_out && !ready_out;
        prev_out   <= {valid_out, data_out, keep_out, last_out};
    end

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode != 0) ready_out = ~ready_out;
            else ready_out = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q;
        pl_d.delete(); pl_k.delete(); pl_l.delete(); in_cyc.delete();
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        obs_d.delete(); obs_k.delete(); obs_l.delete(); obs_c.delete();
    endtask

    // reference model: header bytes followed by payload bytes, chunked densely into W-byte beats
    task automatic make_pkt(input int n, input logic [DW-1:0] hdr, input int nbytes);
        logic [7:0]    all_b[$];
        logic [7:0]    pay[$];
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        for (int j = 0; j < n; j++) all_b.push_back(hdr[8*(n-1-j) +: 8]);
        for (int j = 0; j < nbytes; j++) begin
            logic [7:0] bv;
            bv = 8'($urandom);
            pay.push_back(bv);
            all_b.push_back(bv);
        end
        for (int b = 0; b < nbytes; b += W) begin
            d = DW'($urandom);
            k = '0;
            for (int j = 0; j < W; j++)
                if (b + j < nbytes) begin d[8*(W-1-j) +: 8] = pay[b+j]; k[W-1-j] = 1'b1; end
            pl_d.push_back(d); pl_k.push_back(k); pl_l.push_back(b + W >= nbytes);
        end
        for (int b = 0; b < all_b.size(); b += W) begin
            d = '0;
            k = '0;
            for (int j = 0; j < W; j++)
                if (b + j < all_b.size()) begin d[8*(W-1-j) +: 8] = all_b[b+j]; k[W-1-j] = 1'b1; end
            exp_d.push_back(d); exp_k.push_back(k); exp_l.push_back(b + W >= all_b.size());
        end
    endtask

    task automatic drive_hdr(input int cnt, input logic [DW-1:0] d, input logic [W-1:0] k);
        bit hs;
        hs = 1'b0;
        valid_insert = 1'b1; byte_insert_cnt = CW'(cnt); data_insert = d; keep_insert = k;
        for (int t = 0; t < 300 && !hs; t++) begin
            @(negedge clk); hs = ready_insert;
            @(posedge clk); #1;
        end
        valid_insert = 1'b0;
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL hdr_handshake: ready_insert never seen, got 0 required 1"); end
    endtask

    task automatic drive_payload(input int gap_pct);
        bit hs;
        while (pl_d.size() > 0) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end else begin
                valid_in = 1'b1; data_in = pl_d[0]; keep_in = pl_k[0]; last_in = pl_l[0];
                hs = 1'b0;
                for (int t = 0; t < 300 && !hs; t++) begin
                    @(negedge clk); hs = ready_in;
                    @(posedge clk); #1;
                end
                n_checks++;
                if (!hs) begin
                    n_fail++;
                    $display("FAIL beat_handshake: ready_in never seen, got 0 required 1");
                    pl_d.delete(); pl_k.delete(); pl_l.delete();
                end else begin
                    in_cyc.push_back(cyc);
                    void'(pl_d.pop_front()); void'(pl_k.pop_front()); void'(pl_l.pop_front());
                end
            end
        end
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic wait_out(input int n_exp);
        for (int t = 0; t < 400 && obs_d.size() < n_exp; t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({valid_out, last_out, ready_in, ready_insert, err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {valid_out, last_out, ready_in, ready_insert, err});
        end
        n_checks++;
        if ({data_out, keep_out} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%b required 0/0", data_out, keep_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ready_insert, ready_in} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got ready_insert/ready_in %b required 10", {ready_insert, ready_in});
        end
        @(posedge clk); #1;
    endtask

    task automatic load_case1;
        pl_d.push_back(32'h11223344); pl_k.push_back(4'b1111); pl_l.push_back(1'b0);
        pl_d.push_back(32'h55667788); pl_k.push_back(4'b1100); pl_l.push_back(1'b1);
        exp_d.push_back(32'hCCDD1122); exp_k.push_back(4'b1111); exp_l.push_back(1'b0);
        exp_d.push_back(32'h33445566); exp_k.push_back(4'b1111); exp_l.push_back(1'b1);
    endtask

    task automatic test_case1;
        clear_q();
        load_case1();
        fork drive_hdr(2, 32'hAABBCCDD, 4'b0011); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL case1_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL case1_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL case1_err: got %b required 0", err); end
    endtask

    task automatic test_tail;
        clear_q();
        pl_d.push_back(32'h11223344); pl_k.push_back(4'b1110); pl_l.push_back(1'b1);
        exp_d.push_back(32'hBBCCDD11); exp_k.push_back(4'b1111); exp_l.push_back(1'b0);
        exp_d.push_back(32'h22330000); exp_k.push_back(4'b1100); exp_l.push_back(1'b1);
        fork drive_hdr(3, 32'h00BBCCDD, 4'b0111); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL tail_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL tail_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_passthru;
        logic [DW-1:0] h;
        clear_q();
        h = DW'($urandom);
        make_pkt(0, h, 9);
        fork drive_hdr(0, h, 4'b0000); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL pass_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL pass_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
            if (i < in_cyc.size()) begin
                n_checks++;
                if (obs_c[i] !== in_cyc[i]) begin
                    n_fail++; $display("FAIL pass_latency%0d: output cycle %0d required %0d", i, obs_c[i], in_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_stall;
        int v0;
        clear_q();
        v0 = stall_viol;
        load_case1();
        rdy_mode = 1;
        fork drive_hdr(2, 32'hAABBCCDD, 4'b0011); drive_payload(30); join
        wait_out(exp_d.size());
        rdy_mode = 0;
        @(posedge clk); #1;
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL stall_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        n_checks++;
        if (stall_viol - v0 !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes during stall required 0", stall_viol - v0); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] h1, h2;
        logic [W-1:0]  k2;
        int n2, len1, len2, np1;
        clear_q();
        h1 = DW'($urandom); h2 = DW'($urandom);
        n2 = int'($urandom_range(W, 0));
        k2 = ~({W{1'b1}} << n2);
        len1 = int'($urandom_range(3*W, W+1));
        len2 = int'($urandom_range(3*W, 1));
        make_pkt(W, h1, len1);
        np1 = exp_d.size();
        make_pkt(n2, h2, len2);
        fork
            begin drive_hdr(W, h1, 4'b1111); drive_hdr(n2, h2, k2); end
            drive_payload(0);
        join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL b2b_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        if (obs_c.size() > np1) begin
            n_checks++;
            if (obs_c[np1] !== obs_c[np1-1] + 1) begin
                n_fail++; $display("FAIL b2b_bubble: next packet at cycle %0d required %0d", obs_c[np1], obs_c[np1-1] + 1);
            end
        end

        // reset in the middle of a packet with a second header already buffered
        clear_q();
        fork
            begin drive_hdr(2, DW'($urandom), 4'b0011); drive_hdr(3, DW'($urandom), 4'b0111); end
            begin
                valid_in = 1'b1; keep_in = 4'b1111; last_in = 1'b0;
                for (int i = 0; i < 6; i++) begin data_in = DW'($urandom); @(posedge clk); #1; end
            end
        join
        rst_n = 1'b0; valid_in = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({valid_out, last_out, ready_in, ready_insert, err} !== 5'b0 || {data_out, keep_out} !== '0) begin
            n_fail++; $display("FAIL midrst_out: got %b %h/%b required 00000 0/0", {valid_out, last_out, ready_in, ready_insert, err}, data_out, keep_out);
        end
        rst_n = 1'b1;
        clear_q();
        h1 = DW'($urandom);
        make_pkt(1, h1, 6);
        fork drive_hdr(1, h1, 4'b0001); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL postrst_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL postrst_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_err;
        logic [DW-1:0] h;
        clear_q();
        h = DW'($urandom);
        make_pkt(2, h, 5);
        fork drive_hdr(2, h, 4'b0111); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL errkeep_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL errkeep_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err); end

        clear_q();
        h = DW'($urandom);
        make_pkt(1, h, 3);
        fork drive_hdr(1, h, 4'b0001); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err); end

        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b required 0", err); end
        rst_n = 1'b1;

        // oversized count is clamped to a full-width header and flagged
        clear_q();
        h = DW'($urandom);
        make_pkt(W, h, 3);
        fork drive_hdr(7, h, 4'b1111); drive_payload(0); join
        wait_out(exp_d.size());
        n_checks++;
        if (obs_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL clamp_count: got %0d required %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_checks++;
            if ({obs_d[i], obs_k[i], obs_l[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
                n_fail++; $display("FAIL clamp_beat%0d: got %h/%b/%b required %h/%b/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %b required 1", err); end
    endtask

    initial begin
        test_reset();
        test_case1();
        test_tail();
        test_passthru();
        test_stall();
        for (int r = 0; r < 3; r++) test_back_to_back();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_insert_header_pkt.md
# axis_insert_header_pkt

Streaming header inserter: prepends a per-packet header of 0..DATA_BYTE_WD bytes to an AXI-Stream packet and re-packs the byte stream so output beats are dense. Unlike the single-shot inserter, it handles back-to-back packets at full throughput. A one-entry header buffer lets the next header arrive while the current packet drains, and a registered output stage isolates timing. It sits between a payload source and any downstream AXI-Stream consumer.

## Interface
- DATA_WD, 32, data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (W)
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD+1), width of header byte count
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  payload stream
- ready_in  out  1  payload ready
- valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  packed output stream
- ready_out  in  1  output ready
- valid_insert / data_insert / keep_insert  in  1/DATA_WD/DATA_BYTE_WD  header
- byte_insert_cnt  in  BYTE_CNT_WD  valid header bytes n (0..W)
- ready_insert  out  1  header ready
- err  out  1  sticky protocol-error flag, cleared only by reset

## Operation
- Byte order: byte 0 = data[DATA_WD-1 -: 8], keep bit W-1 marks byte 0.
- Header valid bytes are the n LSB-end bytes; keep_insert must equal (1<<n)-1.
- Payload keep is all-ones on non-last beats. On the last beat it holds k≥1 contiguous ones from MSB.
- Output keep is all-ones except on last beat, which is MSB-aligned. Invalid output bytes are driven 0.
- Header buffer hdr_v (1 entry). ready_insert = !hdr_v while rst_n=1, else 0. Accepted header is stored with n clamped to W.
- Hold register H (up to W bytes) with count h.
- States:
  - IDLE: ready_in=0. If hdr_v, load H/h from header, clear hdr_v, go DATA.
  - DATA: ready_in=adv, where adv = !valid_out || ready_out. Each accepted beat outputs {H[h bytes], top W-h bytes of data_in}; H receives the low h bytes of data_in.
    - Last beat, h+k ≤ W: output last_out=1, keep = top h+k ones. If hdr_v, load next header and stay DATA; else go IDLE.
    - Last beat, h+k > W: output a full beat, set h = h+k-W, go TAIL.
  - TAIL: ready_in=0. When adv, emit H with keep = top h ones and last_out=1. Then load next header and go DATA if hdr_v, else go IDLE.
- n=0 is pure pass-through. n=W emits the whole header beat first.
- err sets when any of these occur (processing continues):
  - keep_insert ≠ (1<<n)-1; byte_insert_cnt governs.
  - byte_insert_cnt > W.
  - Non-last keep_in ≠ all-ones; the beat is treated as full.
  - Last keep_in = 0; treated as k=0.

## Timing
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0 (while rst_n=0), err=0. State resets to IDLE and hdr_v=0.
- Reset mid-packet discards the header buffer, H, and the output register. No partial beat is emitted after reset.
- Latency: payload beat accepted at edge t appears on the output after edge t; valid_out is registered.
- Header accepted at edge t: IDLE loads at t+1, ready_in rises after t+1.
- Output holds data/keep/last stable while valid_out && !ready_out.
- Throughput: 1 beat/cycle sustained. No bubble between packets when the next header is buffered before the last beat.
- TAIL adds exactly one output beat. IDLE with an empty header buffer costs one cycle per packet.

## Test plan
- DATA_WD=32, n=2, header 0xAABBCCDD keep 0011; payload 0x11223344, then 0x55667788 last keep 1100 -> outputs 0xCCDD1122 keep 1111, then 0x33445566 keep 1111 last.
- n=3, header 0x00BBCCDD keep 0111; single beat 0x11223344 keep 1110 last -> outputs 0xBBCCDD11 keep 1111, then 0x22330000 keep 1100 last.
- n=0; three random beats with last keep 1000 -> output identical to input, one-cycle delay.
- Case 1 with ready_out toggling 1010... and random valid_in gaps -> same output sequence, no loss or duplication, output stable during stall.
- Two packets back-to-back with the second header presented during the first packet -> no idle cycle between last_out and next valid_out. Then assert rst_n=0 mid-packet for one cycle -> all outputs 0, next packet correct.
- Header n=2 with keep_insert 0111 -> err=1 and stays 1; output packed per n=2.
